// File: rtl/h14rx_period_tracker.sv
// HDMI 1.4 receive period tracker: classifies aligned TMDS symbols into control,
// video and data-island periods, recovers sync and flags protocol violations.
package h14rx_period_tracker_pkg;
  typedef logic [9:0] symbol_t;
endpackage

module h14rx_period_tracker
  import h14rx_period_tracker_pkg::*;
#(
  parameter int unsigned MinPreamble = 8,
  parameter int unsigned MaxPackets  = 18
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    symbol_valid,
  input  symbol_t symbol_0,
  input  symbol_t symbol_1,
  input  symbol_t symbol_2,
  output logic    out_valid,
  output symbol_t out_symbol_0,
  output symbol_t out_symbol_1,
  output symbol_t out_symbol_2,
  output logic    video_de,
  output logic    island_de,
  output logic    packet_start,
  output logic    hsync,
  output logic    vsync,
  output logic    err
);

  localparam int unsigned PktW = $clog2(MaxPackets + 1);
  localparam symbol_t GUARD_A = 10'b1011001100;
  localparam symbol_t GUARD_B = 10'b0100110011;

  typedef enum logic [2:0] {
    CTRL, PRE_V, PRE_D, GUARD_V, GUARD_D_LEAD, VIDEO, ISLAND, GUARD_D_TRAIL
  } state_t;

  // {is_control, D1, D0}
  function automatic logic [2:0] ctl_dec(input symbol_t s);
    case (s)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // {is_terc4, nibble}
  function automatic logic [4:0] terc4_dec(input symbol_t s);
    case (s)
      10'b1010011100: return 5'h10;
      10'b1001100011: return 5'h11;
      10'b1011100100: return 5'h12;
      10'b1011100010: return 5'h13;
      10'b0101110001: return 5'h14;
      10'b0100011110: return 5'h15;
      10'b0110001110: return 5'h16;
      10'b0100111100: return 5'h17;
      10'b1011001100: return 5'h18;
      10'b0100111001: return 5'h19;
      10'b0110011100: return 5'h1A;
      10'b1011000110: return 5'h1B;
      10'b1010001110: return 5'h1C;
      10'b1001110001: return 5'h1D;
      10'b0101100011: return 5'h1E;
      10'b1011000011: return 5'h1F;
      default:        return 5'h00;
    endcase
  endfunction

  state_t            state, state_n;
  logic [3:0]        pre_cnt, pre_n;
  logic [1:0]        g_cnt, g_n;
  logic [4:0]        sym_idx, sym_n;
  logic [PktW-1:0]   pkt_cnt, pkt_n;
  logic              err_n, vde_n, ide_n, pstart_n, sync_upd;
  logic [1:0]        sync_n;

  logic [2:0] c0, c1, c2;
  logic [4:0] t0;
  logic       all_ctl, pre_v_sym, pre_d_sym, vguard, iguard;
  state_t     enter_state;
  logic [3:0] enter_pre;

  always_comb begin
    c0        = ctl_dec(symbol_0);
    c1        = ctl_dec(symbol_1);
    c2        = ctl_dec(symbol_2);
    t0        = terc4_dec(symbol_0);
    all_ctl   = c0[2] & c1[2] & c2[2];
    pre_v_sym = all_ctl && c1[1:0] == 2'b01 && c2[1:0] == 2'b00;
    pre_d_sym = all_ctl && c1[1:0] == 2'b01 && c2[1:0] == 2'b01;
    vguard    = symbol_0 == GUARD_A && symbol_1 == GUARD_B && symbol_2 == GUARD_A;
    iguard    = symbol_1 == GUARD_B && symbol_2 == GUARD_B && t0[4] && t0[3:2] == 2'b11;
    enter_state = pre_v_sym ? PRE_V : (pre_d_sym ? PRE_D : CTRL);
    enter_pre   = (pre_v_sym || pre_d_sym) ? 4'd1 : 4'd0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CTRL;
      pre_cnt <= '0;
      g_cnt   <= '0;
      sym_idx <= '0;
      pkt_cnt <= '0;
    end else begin
      state   <= state_n;
      pre_cnt <= pre_n;
      g_cnt   <= g_n;
      sym_idx <= sym_n;
      pkt_cnt <= pkt_n;
    end
  end

  // Next-state: a guard counter of 2 means both guard symbols were seen, so the
  // current symbol is the first one past the band.
  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    g_n     = g_cnt;
    sym_n   = sym_idx;
    pkt_n   = pkt_cnt;
    err_n   = 1'b0;
    if (symbol_valid) begin
      case (state)
        CTRL: begin
          state_n = enter_state;
          pre_n   = enter_pre;
        end
        PRE_V, PRE_D: begin
          if ((state == PRE_V && pre_v_sym) || (state == PRE_D && pre_d_sym)) begin
            pre_n = (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
          end else if (pre_v_sym || pre_d_sym) begin
            state_n = enter_state;
            pre_n   = 4'd1;
          end else if (state == PRE_V && vguard) begin
            if (32'(pre_cnt) >= MinPreamble) begin
              state_n = GUARD_V;
              g_n     = 2'd1;
              pre_n   = '0;
            end else begin
              err_n = 1'b1;
            end
          end else if (state == PRE_D && iguard) begin
            if (32'(pre_cnt) >= MinPreamble) begin
              state_n = GUARD_D_LEAD;
              g_n     = 2'd1;
              pre_n   = '0;
            end else begin
              err_n = 1'b1;
            end
          end else if (all_ctl) begin
            state_n = CTRL;
            pre_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        GUARD_V: begin
          if (g_cnt == 2'd1) begin
            if (vguard) g_n = 2'd2;
            else        err_n = 1'b1;
          end else if (vguard) begin
            err_n = 1'b1;
          end else if (all_ctl) begin
            state_n = enter_state;
            pre_n   = enter_pre;
            g_n     = '0;
          end else begin
            state_n = VIDEO;
            g_n     = '0;
          end
        end
        VIDEO: begin
          if (all_ctl) begin
            state_n = enter_state;
            pre_n   = enter_pre;
          end
        end
        GUARD_D_LEAD: begin
          if (g_cnt == 2'd1) begin
            if (iguard) g_n = 2'd2;
            else        err_n = 1'b1;
          end else if (iguard) begin
            err_n = 1'b1;
          end else begin
            state_n = ISLAND;
            g_n     = '0;
            sym_n   = 5'd1;
            pkt_n   = PktW'(1);
          end
        end
        ISLAND: begin
          if (sym_idx != 5'd0) begin
            sym_n = sym_idx + 5'd1;
          end else if (iguard) begin
            state_n = GUARD_D_TRAIL;
            g_n     = 2'd1;
            pkt_n   = '0;
          end else if (pkt_cnt == PktW'(MaxPackets)) begin
            err_n = 1'b1;
          end else begin
            pkt_n = pkt_cnt + PktW'(1);
            sym_n = 5'd1;
          end
        end
        GUARD_D_TRAIL: begin
          if (g_cnt == 2'd1) begin
            if (iguard) g_n = 2'd2;
            else        err_n = 1'b1;
          end else if (iguard) begin
            err_n = 1'b1;
          end else begin
            state_n = enter_state;
            pre_n   = enter_pre;
            g_n     = '0;
          end
        end
        default: state_n = CTRL;
      endcase
      if (err_n) begin
        state_n = CTRL;
        pre_n   = '0;
        g_n     = '0;
        sym_n   = '0;
        pkt_n   = '0;
      end
    end
  end

  // Output decode for the symbol being accepted this cycle
  always_comb begin
    vde_n    = 1'b0;
    ide_n    = 1'b0;
    pstart_n = 1'b0;
    sync_upd = 1'b0;
    sync_n   = {vsync, hsync};
    if (symbol_valid) begin
      if (!err_n) begin
        vde_n = !all_ctl && (state == VIDEO || (state == GUARD_V && g_cnt == 2'd2));
        pstart_n = (state == ISLAND && sym_idx == 5'd0 && !iguard) ||
                   (state == GUARD_D_LEAD && g_cnt == 2'd2);
        ide_n = pstart_n || (state == ISLAND && sym_idx != 5'd0);
      end
      if (all_ctl) begin
        sync_upd = 1'b1;
        sync_n   = c0[1:0];
      end else if (iguard && (state == PRE_D || state == GUARD_D_LEAD ||
                              state == ISLAND || state == GUARD_D_TRAIL)) begin
        sync_upd = 1'b1;
        sync_n   = t0[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_symbol_0 <= '0;
      out_symbol_1 <= '0;
      out_symbol_2 <= '0;
      video_de     <= 1'b0;
      island_de    <= 1'b0;
      packet_start <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      err          <= 1'b0;
    end else begin
      out_valid    <= symbol_valid;
      out_symbol_0 <= symbol_0;
      out_symbol_1 <= symbol_1;
      out_symbol_2 <= symbol_2;
      video_de     <= vde_n;
      island_de    <= ide_n;
      packet_start <= pstart_n;
      err          <= err_n;
      if (sync_upd) begin
        vsync <= sync_n[1];
        hsync <= sync_n[0];
      end
    end
  end

endmodule

// File: tb/tb_h14rx_period_tracker.sv
// Directed-vector bench for h14rx_period_tracker: video, island, error and reset scenarios.
module tb_h14rx_period_tracker;
  import h14rx_period_tracker_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    symbol_valid = 1'b0;
  symbol_t symbol_0 = '0, symbol_1 = '0, symbol_2 = '0;
  logic    out_valid, video_de, island_de, packet_start, hsync, vsync, err;
  symbol_t out_symbol_0, out_symbol_1, out_symbol_2;

  int tests = 0;
  int fails = 0;

  localparam symbol_t CTL00 = 10'b1101010100;
  localparam symbol_t CTL01 = 10'b0010101011;
  localparam symbol_t CTL10 = 10'b0101010100;
  localparam symbol_t CTL11 = 10'b1010101011;
  localparam symbol_t GA    = 10'b1011001100;
  localparam symbol_t GB    = 10'b0100110011;

  symbol_t terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  h14rx_period_tracker #(.MinPreamble(8), .MaxPackets(18)) dut (
    .clk(clk), .rst_n(rst_n), .symbol_valid(symbol_valid),
    .symbol_0(symbol_0), .symbol_1(symbol_1), .symbol_2(symbol_2),
    .out_valid(out_valid), .out_symbol_0(out_symbol_0), .out_symbol_1(out_symbol_1),
    .out_symbol_2(out_symbol_2), .video_de(video_de), .island_de(island_de),
    .packet_start(packet_start), .hsync(hsync), .vsync(vsync), .err(err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input symbol_t a, input symbol_t b, input symbol_t c);
    symbol_valid = v;
    symbol_0 = a;
    symbol_1 = b;
    symbol_2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, CTL00, CTL00, CTL00);
  endtask

  task automatic test_reset();
    tests++;
    if ({out_valid, video_de, island_de, packet_start, hsync, vsync, err,
         out_symbol_0, out_symbol_1, out_symbol_2} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs got %b exp 0", {out_valid, video_de, island_de,
               packet_start, hsync, vsync, err, out_symbol_0, out_symbol_1, out_symbol_2});
    end
  endtask

  task automatic test_video();
    logic exp;
    idle(2);
    for (int i = 0; i < 15; i++) begin
      if (i < 8)       drive(1'b1, CTL11, CTL01, CTL00);
      else if (i < 10) drive(1'b1, GA, GB, GA);
      else if (i < 14) drive(1'b1, symbol_t'(10'h0F0 + i), 10'h1E1, 10'h2C3);
      else             drive(1'b1, CTL10, CTL00, CTL00);
      exp = (i >= 10 && i < 14);
      tests++;
      if (video_de !== exp) begin
        fails++; $display("FAIL video_de step %0d got %b exp %b", i, video_de, exp);
      end
      tests++;
      if (err !== 1'b0) begin
        fails++; $display("FAIL video_err step %0d got %b exp 0", i, err);
      end
      if (i == 0) begin
        tests++;
        if ({vsync, hsync} !== 2'b11) begin
          fails++; $display("FAIL video_sync_pre got %b exp 11", {vsync, hsync});
        end
      end
      if (i == 11) begin
        tests++;
        if (out_symbol_0 !== 10'h0FB) begin
          fails++; $display("FAIL video_out_symbol got %h exp 0fb", out_symbol_0);
        end
      end
    end
    tests++;
    if ({vsync, hsync} !== 2'b10) begin
      fails++; $display("FAIL video_sync_end got %b exp 10", {vsync, hsync});
    end
  endtask

  task automatic test_short_preamble();
    int errs = 0;
    idle(2);
    for (int i = 0; i < 12; i++) begin
      if (i < 7)      drive(1'b1, CTL00, CTL01, CTL00);
      else if (i < 9) drive(1'b1, GA, GB, GA);
      else            drive(1'b1, 10'h0F5, 10'h1E1, 10'h2C3);
      if (err === 1'b1) errs++;
      tests++;
      if (video_de !== 1'b0) begin
        fails++; $display("FAIL short_pre_video_de step %0d got %b exp 0", i, video_de);
      end
      if (i == 7) begin
        tests++;
        if (err !== 1'b1) begin
          fails++; $display("FAIL short_pre_err_at_guard got %b exp 1", err);
        end
      end
    end
    tests++;
    if (errs != 1) begin
      fails++; $display("FAIL short_pre_err_count got %0d exp 1", errs);
    end
  endtask

  task automatic test_guard_length();
    idle(2);
    for (int i = 0; i < 8; i++) drive(1'b1, CTL00, CTL01, CTL00);
    drive(1'b1, GA, GB, GA);
    drive(1'b1, GA, GB, GA);
    drive(1'b1, GA, GB, GA);
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL guard_three_err got %b exp 1", err);
    end
    drive(1'b1, 10'h0F5, 10'h1E1, 10'h2C3);
    tests++;
    if (video_de !== 1'b0) begin
      fails++; $display("FAIL guard_three_video_de got %b exp 0", video_de);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, CTL00, CTL01, CTL00);
    drive(1'b1, GA, GB, GA);
    drive(1'b1, 10'h0F5, 10'h1E1, 10'h2C3);
    tests++;
    if ({err, video_de} !== 2'b10) begin
      fails++; $display("FAIL guard_one_err got %b exp 10", {err, video_de});
    end
  endtask

  task automatic test_island();
    logic exp_ps;
    idle(2);
    for (int i = 0; i < 8; i++) drive(1'b1, CTL00, CTL01, CTL01);
    for (int i = 0; i < 2; i++) drive(1'b1, terc4[13], GB, GB);
    tests++;
    if ({vsync, hsync, island_de} !== 3'b010) begin
      fails++; $display("FAIL island_lead_guard got %b exp 010", {vsync, hsync, island_de});
    end
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, terc4[i % 16], terc4[(i + 3) % 16], terc4[(i + 7) % 16]);
      exp_ps = (i == 0 || i == 32);
      tests++;
      if ({island_de, packet_start, err} !== {1'b1, exp_ps, 1'b0}) begin
        fails++;
        $display("FAIL island_data sym %0d got %b exp %b", i,
                 {island_de, packet_start, err}, {1'b1, exp_ps, 1'b0});
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, terc4[14], GB, GB);
      tests++;
      if ({island_de, packet_start, err} !== 3'b000) begin
        fails++; $display("FAIL island_trail_guard %0d got %b exp 000", i,
                          {island_de, packet_start, err});
      end
    end
    tests++;
    if ({vsync, hsync} !== 2'b10) begin
      fails++; $display("FAIL island_trail_sync got %b exp 10", {vsync, hsync});
    end
    drive(1'b1, CTL00, CTL00, CTL00);
    tests++;
    if ({err, island_de, vsync, hsync} !== 4'b0000) begin
      fails++; $display("FAIL island_ctrl_after got %b exp 0000", {err, island_de, vsync, hsync});
    end
  endtask

  task automatic test_max_packets();
    int starts = 0;
    idle(2);
    for (int i = 0; i < 8; i++) drive(1'b1, CTL00, CTL01, CTL01);
    for (int i = 0; i < 2; i++) drive(1'b1, terc4[12], GB, GB);
    for (int i = 0; i < 18 * 32; i++) begin
      drive(1'b1, terc4[i % 16], terc4[(i + 5) % 16], terc4[(i + 9) % 16]);
      if (packet_start === 1'b1) starts++;
      tests++;
      if ({island_de, err} !== 2'b10) begin
        fails++; $display("FAIL maxpkt_data sym %0d got %b exp 10", i, {island_de, err});
      end
    end
    tests++;
    if (starts != 18) begin
      fails++; $display("FAIL maxpkt_starts got %0d exp 18", starts);
    end
    drive(1'b1, terc4[1], terc4[2], terc4[3]);
    tests++;
    if ({err, island_de, packet_start} !== 3'b100) begin
      fails++; $display("FAIL maxpkt_overrun got %b exp 100", {err, island_de, packet_start});
    end
    drive(1'b1, terc4[4], terc4[5], terc4[6]);
    tests++;
    if ({err, island_de} !== 2'b00) begin
      fails++; $display("FAIL maxpkt_in_ctrl got %b exp 00", {err, island_de});
    end
  endtask

  task automatic test_valid_gaps();
    logic exp;
    int vi = 0;
    idle(2);
    for (int s = 0; s < 18; s++) begin
      if (s >= 4 && s < 7) begin
        drive(1'b0, 10'h0F5, 10'h1E1, 10'h2C3);
        tests++;
        if ({out_valid, video_de, err} !== 3'b000) begin
          fails++; $display("FAIL gap_invalid step %0d got %b exp 000", s,
                            {out_valid, video_de, err});
        end
      end else begin
        if (vi < 8)       drive(1'b1, CTL00, CTL01, CTL00);
        else if (vi < 10) drive(1'b1, GA, GB, GA);
        else if (vi < 14) drive(1'b1, 10'h0F5, 10'h1E1, 10'h2C3);
        else              drive(1'b1, CTL00, CTL00, CTL00);
        exp = (vi >= 10 && vi < 14);
        tests++;
        if ({out_valid, video_de, err} !== {1'b1, exp, 1'b0}) begin
          fails++; $display("FAIL gap_valid step %0d got %b exp %b", s,
                            {out_valid, video_de, err}, {1'b1, exp, 1'b0});
        end
        vi++;
      end
    end
  endtask

  task automatic test_reset_mid_island();
    int hits = 0;
    idle(2);
    for (int i = 0; i < 8; i++) drive(1'b1, CTL00, CTL01, CTL01);
    for (int i = 0; i < 2; i++) drive(1'b1, terc4[15], GB, GB);
    for (int i = 0; i < 10; i++) drive(1'b1, terc4[i], terc4[i + 1], terc4[i + 2]);
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, terc4[i % 16], terc4[(i + 1) % 16], terc4[(i + 2) % 16]);
      if (island_de === 1'b1 || err === 1'b1) hits++;
    end
    for (int i = 0; i < 2; i++) drive(1'b1, terc4[12], GB, GB);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, terc4[i % 16], terc4[(i + 1) % 16], terc4[(i + 2) % 16]);
      if (island_de === 1'b1 || err === 1'b1) hits++;
    end
    tests++;
    if (hits != 0) begin
      fails++; $display("FAIL rst_island_no_de got %0d exp 0", hits);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, CTL00, CTL01, CTL01);
    for (int i = 0; i < 2; i++) drive(1'b1, terc4[12], GB, GB);
    drive(1'b1, terc4[3], terc4[4], terc4[5]);
    tests++;
    if ({island_de, packet_start} !== 2'b11) begin
      fails++; $display("FAIL rst_island_recover got %b exp 11", {island_de, packet_start});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_video();
    test_short_preamble();
    test_guard_length();
    test_island();
    test_max_packets();
    test_valid_gaps();
    test_reset_mid_island();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
